// File: rtl/transfer_datapath.sv
// Register-transfer datapath behind the microcoded control unit: PC, SP, MA, MD,
// IR, A, AP and OUT, with one 4-bit transfer command executed per clock.
module transfer_datapath #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PC_INIT = 8'h00,
    parameter logic [DATA_W-1:0] SP_INIT = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_transfer_cmd,
    input  logic              i_inc_pc,
    input  logic [1:0]        i_inc_dec_sp,
    input  logic              i_alu_res_to_ap,
    input  logic              i_reset_ir,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic [7:0]        o_opcode,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_ap,
    output logic [DATA_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_sp,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid
);

    typedef enum logic [3:0] {
        CMD_NOP      = 4'h0,
        CMD_MA_PC    = 4'h1,
        CMD_MD_MEM   = 4'h2,
        CMD_IR_MD    = 4'h3,
        CMD_MA_MD    = 4'h4,
        CMD_ACC_MD   = 4'h5,
        CMD_MA_AP    = 4'h6,
        CMD_MA_SP    = 4'h7,
        CMD_MD_ACC   = 4'h8,
        CMD_MEM_WR   = 4'h9,
        CMD_ACC_ALU  = 4'hA,
        CMD_PC_MD    = 4'hB,
        CMD_A_IN     = 4'hC,
        CMD_OUT_A    = 4'hD,
        CMD_PC_AP    = 4'hE,
        CMD_MD_PC    = 4'hF
    } cmd_e;

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] sp_q, sp_d;
    logic [DATA_W-1:0] ma_q, ma_d;
    logic [DATA_W-1:0] md_q, md_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] ap_q, ap_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;

    cmd_e cmd;
    logic sel_ap;

    assign cmd = cmd_e'(i_transfer_cmd);

    // Opcodes whose memory operand lives in AP rather than A.
    assign sel_ap = ir_q[1] | (ir_q == DATA_W'(8'hC1));

    always_comb begin
        pc_d        = pc_q;
        sp_d        = sp_q;
        ma_d        = ma_q;
        md_d        = md_q;
        ir_d        = ir_q;
        a_d         = a_q;
        ap_d        = ap_q;
        out_d       = out_q;
        out_valid_d = 1'b0;

        if (i_inc_pc) begin
            pc_d = pc_q + DATA_W'(1);
        end

        case (i_inc_dec_sp)
            2'b01:   sp_d = sp_q + DATA_W'(1);
            2'b10:   sp_d = sp_q - DATA_W'(1);
            default: sp_d = sp_q;
        endcase

        if (i_reset_ir) begin
            ir_d = '0;
        end

        // Placed after the strobes so that a load of PC or IR overrides them.
        case (cmd)
            CMD_MA_PC:   ma_d = pc_q;
            CMD_MD_MEM:  md_d = i_mem_rdata;
            CMD_IR_MD:   ir_d = md_q;
            CMD_MA_MD:   ma_d = md_q;
            CMD_ACC_MD: begin
                if (sel_ap) ap_d = md_q;
                else        a_d  = md_q;
            end
            CMD_MA_AP:   ma_d = ap_q;
            CMD_MA_SP:   ma_d = sp_q;
            CMD_MD_ACC:  md_d = sel_ap ? ap_q : a_q;
            CMD_ACC_ALU: begin
                if (i_alu_res_to_ap) ap_d = i_alu_result;
                else                 a_d  = i_alu_result;
            end
            CMD_PC_MD:   pc_d = md_q;
            CMD_A_IN:    a_d  = i_in_data;
            CMD_OUT_A: begin
                out_d       = a_q;
                out_valid_d = 1'b1;
            end
            CMD_PC_AP:   pc_d = ap_q;
            CMD_MD_PC:   md_d = pc_q;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q        <= PC_INIT;
            sp_q        <= SP_INIT;
            ma_q        <= '0;
            md_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            ap_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            sp_q        <= sp_d;
            ma_q        <= ma_d;
            md_q        <= md_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            ap_q        <= ap_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o_mem_we    = (cmd == CMD_MEM_WR) & ~i_rst;
    assign o_mem_addr  = ma_q;
    assign o_mem_wdata = md_q;
    assign o_opcode    = ir_q[7:0];
    assign o_a         = a_q;
    assign o_ap        = ap_q;
    assign o_pc        = pc_q;
    assign o_sp        = sp_q;
    assign o_out_data  = out_q;
    assign o_out_valid = out_valid_q;

endmodule

// File: tb/tb_transfer_datapath.sv
// Directed bench for transfer_datapath: stimulus queues expected values, a negedge
// monitor pops and compares them against register, memory-write and OUT activity.
module tb_transfer_datapath;

    localparam int SIG_PC = 0, SIG_SP = 1, SIG_MA = 2, SIG_MD = 3, SIG_IR = 4,
                   SIG_A = 5, SIG_AP = 6, SIG_OUT = 7, SIG_WE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cmd = 4'h0;
    logic       inc_pc = 1'b0;
    logic [1:0] sp_strb = 2'b00;
    logic       alu_to_ap = 1'b0;
    logic       reset_ir = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic [7:0] in_data = 8'h00;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr, mem_wdata, opcode, a, ap, pc, sp, out_data;
    logic       mem_we, out_valid;

    logic [7:0] mem [256];

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      nm;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] out_q[$];
    logic [15:0] mem_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    transfer_datapath dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_transfer_cmd  (cmd),
        .i_inc_pc        (inc_pc),
        .i_inc_dec_sp    (sp_strb),
        .i_alu_res_to_ap (alu_to_ap),
        .i_reset_ir      (reset_ir),
        .i_alu_result    (alu_result),
        .i_in_data       (in_data),
        .i_mem_rdata     (mem_rdata),
        .o_mem_addr      (mem_addr),
        .o_mem_wdata     (mem_wdata),
        .o_mem_we        (mem_we),
        .o_opcode        (opcode),
        .o_a             (a),
        .o_ap            (ap),
        .o_pc            (pc),
        .o_sp            (sp),
        .o_out_data      (out_data),
        .o_out_valid     (out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    function automatic logic [7:0] probe(input int sig);
        case (sig)
            SIG_PC:  return pc;
            SIG_SP:  return sp;
            SIG_MA:  return mem_addr;
            SIG_MD:  return mem_wdata;
            SIG_IR:  return opcode;
            SIG_A:   return a;
            SIG_AP:  return ap;
            SIG_OUT: return out_data;
            default: return {7'b0, mem_we};
        endcase
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", nm, act, req, cyc);
        end else begin
            $display("ok   %s: %02h (cycle %0d)", nm, act, cyc);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] m;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check(e.nm, probe(e.sig), e.val);
        end
        if (mem_we) begin
            if (mem_q.size() == 0) begin
                check("mem_we_unexpected", 8'h01, 8'h00);
            end else begin
                m = mem_q.pop_front();
                check("mem_wr_addr", mem_addr, m[15:8]);
                check("mem_wr_data", mem_wdata, m[7:0]);
            end
        end
        if (out_valid) begin
            if (out_q.size() == 0) begin
                check("out_valid_unexpected", 8'h01, 8'h00);
            end else begin
                check("out_data", out_data, out_q.pop_front());
            end
        end
    end

    // Drive one command; it takes effect at the next rising edge.
    task automatic go(input logic [3:0] c, input logic [7:0] d = 8'h00,
                      input logic inc = 1'b0, input logic [1:0] s = 2'b00,
                      input logic to_ap = 1'b0, input logic rir = 1'b0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        cmd        = c;
        in_data    = d;
        alu_result = d;
        inc_pc     = inc;
        sp_strb    = s;
        alu_to_ap  = to_ap;
        reset_ir   = rir;
    endtask

    // Expectation on state after the edge that executes the command just driven.
    task automatic expect_next(input int sig, input logic [7:0] v, input string nm);
        exp_q.push_back('{cyc + 1, sig, v, nm});
    endtask

    // Expectation on a combinational output during the current cycle.
    task automatic expect_now(input int sig, input logic [7:0] v, input string nm);
        exp_q.push_back('{cyc, sig, v, nm});
    endtask

    task automatic expect_reset_state(input string tag);
        expect_next(SIG_PC, 8'h00, {tag, "_pc"});
        expect_next(SIG_SP, 8'hFF, {tag, "_sp"});
        expect_next(SIG_MA, 8'h00, {tag, "_ma"});
        expect_next(SIG_MD, 8'h00, {tag, "_md"});
        expect_next(SIG_IR, 8'h00, {tag, "_ir"});
        expect_next(SIG_A, 8'h00, {tag, "_a"});
        expect_next(SIG_AP, 8'h00, {tag, "_ap"});
        expect_next(SIG_OUT, 8'h00, {tag, "_out"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h19;
        mem[8'h11] = 8'h13;
        mem[8'h13] = 8'h5A;
        mem[8'h20] = 8'hC1;
        mem[8'hC1] = 8'h5A;

        repeat (2) @(posedge clk);
        #1;
        expect_reset_state("rst");

        // Preset PC=0x10 through A -> MD -> PC.
        go(4'hC, 8'h10);
        go(4'h8);          expect_next(SIG_MD, 8'h10, "preset_md");
        go(4'hB);          expect_next(SIG_PC, 8'h10, "preset_pc");

        // Fetch.
        go(4'h1);          expect_next(SIG_MA, 8'h10, "fetch_ma");
        go(4'h2, 8'h00, 1'b1);
        expect_next(SIG_MD, 8'h19, "fetch_md");
        expect_next(SIG_PC, 8'h11, "fetch_pc");
        go(4'h3);          expect_next(SIG_IR, 8'h19, "fetch_opcode");

        // IR=0x13: cmd 5 writes AP.
        go(4'h1); go(4'h2); go(4'h3);
        expect_next(SIG_IR, 8'h13, "ir_13");
        go(4'h4); go(4'h2);
        go(4'h5);
        expect_next(SIG_AP, 8'h5A, "sel13_ap");
        expect_next(SIG_A, 8'h10, "sel13_a_kept");

        // IR=0x11: cmd 5 writes A.
        go(4'hA, 8'h11, 1'b0, 2'b00, 1'b1);
        go(4'h8);          expect_next(SIG_MD, 8'h11, "md_from_ap");
        go(4'h3);
        go(4'h2);
        go(4'h5);
        expect_next(SIG_A, 8'h5A, "sel11_a");
        expect_next(SIG_AP, 8'h11, "sel11_ap_kept");

        // IR=0xC1: cmd 5 writes AP via the exact-match term.
        go(4'hA, 8'h20, 1'b0, 2'b00, 1'b1);
        go(4'h6);          expect_next(SIG_MA, 8'h20, "ma_from_ap");
        go(4'h2); go(4'h3);
        expect_next(SIG_IR, 8'hC1, "ir_c1");
        go(4'h4); go(4'h2);
        go(4'h5);          expect_next(SIG_AP, 8'h5A, "selC1_ap");

        // Stack pointer wrap.
        go(4'h0, 8'h00, 1'b0, 2'b01); expect_next(SIG_SP, 8'h00, "sp_inc_wrap");
        go(4'h0, 8'h00, 1'b0, 2'b10); expect_next(SIG_SP, 8'hFF, "sp_dec_wrap");
        go(4'h7, 8'h00, 1'b0, 2'b01);
        expect_next(SIG_MA, 8'hFF, "push_ma_pre_sp");
        expect_next(SIG_SP, 8'h00, "push_sp");
        go(4'h0, 8'h00, 1'b0, 2'b11); expect_next(SIG_SP, 8'h00, "sp_hold_11");

        // Store A=0x3C to 0x80 with IR=0x21.
        go(4'hA, 8'h21, 1'b0, 2'b00, 1'b1);
        go(4'h8); go(4'h3); expect_next(SIG_IR, 8'h21, "ir_21");
        go(4'hA, 8'h80, 1'b0, 2'b00, 1'b1);
        go(4'h6);
        go(4'hC, 8'h3C);
        go(4'h8);          expect_next(SIG_MD, 8'h3C, "store_md");
        go(4'h9);
        expect_now(SIG_WE, 8'h01, "store_we_high");
        mem_q.push_back({8'h80, 8'h3C});
        go(4'hF);
        expect_now(SIG_WE, 8'h00, "store_we_low");
        expect_next(SIG_MD, 8'h11, "md_from_pc");
        go(4'h2);          expect_next(SIG_MD, 8'h3C, "store_readback");

        // Priority cases.
        go(4'hC, 8'hFF); go(4'h8);
        go(4'hB);          expect_next(SIG_PC, 8'hFF, "pc_ff");
        go(4'h0, 8'h00, 1'b1); expect_next(SIG_PC, 8'h00, "pc_wrap");
        go(4'hC, 8'h40); go(4'h8);
        go(4'hB, 8'h00, 1'b1); expect_next(SIG_PC, 8'h40, "load_beats_inc");
        go(4'hC, 8'h77); go(4'h8);
        go(4'h3, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1); expect_next(SIG_IR, 8'h77, "cmd3_beats_reset_ir");
        go(4'h0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1); expect_next(SIG_IR, 8'h00, "reset_ir");
        go(4'hC, 8'h22); go(4'h8); go(4'hB);
        go(4'hF, 8'h00, 1'b1);
        expect_next(SIG_MD, 8'h22, "md_pre_inc_pc");
        expect_next(SIG_PC, 8'h23, "pc_after_cmdF");
        go(4'hE, 8'h00, 1'b1); expect_next(SIG_PC, 8'h80, "pc_from_ap");
        go(4'hA, 8'h99);
        expect_next(SIG_A, 8'h99, "alu_to_a");
        expect_next(SIG_AP, 8'h80, "alu_ap_kept");

        // Input and output port, including back-to-back OUT.
        go(4'hC, 8'hA5);   expect_next(SIG_A, 8'hA5, "in_to_a");
        go(4'hD);          out_q.push_back(8'hA5); expect_next(SIG_OUT, 8'hA5, "out_reg");
        go(4'hD);          out_q.push_back(8'hA5);
        go(4'hC, 8'h5B);
        go(4'hD);          out_q.push_back(8'h5B);
        go(4'h0);

        // Reset asserted mid-write with strobes active.
        @(posedge clk);
        #1;
        rst = 1'b1; cmd = 4'h9; inc_pc = 1'b1; sp_strb = 2'b01; reset_ir = 1'b0;
        expect_now(SIG_WE, 8'h00, "we_blocked_by_rst");
        expect_reset_state("rst2");
        go(4'h0, 8'h00, 1'b1); expect_next(SIG_PC, 8'h01, "pc_after_rst");
        go(4'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;

        check("exp_q_drained", 8'(exp_q.size()), 8'h00);
        check("out_q_drained", 8'(out_q.size()), 8'h00);
        check("mem_q_drained", 8'(mem_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
